axi_lite_cmd_master: RTL and testbench

Hardware AXI4-Lite master that turns a simple valid/ready command stream into single AXI4-Lite read or write transactions. It sits directly upstream of the HDMI text controller's AXI slave port and drives its VRAM and control-register space from on-chip logic without a processor. It runs one transaction at a time and returns one response per command. It also keeps transaction and error counters for bring-up.

---
 rtl/axi_lite_pkg.sv | 29 ++
 rtl/axi_lite_cmd_master.sv | 255 +++++++++++++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, command-master FSM states and
// small counter helpers.
package axi_lite_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_cmd_master.sv
// Command-stream to AXI4-Lite master: one outstanding read or write at a time,
// one response per command, plus bring-up transaction/error counters.
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                axi_aclk,
    input  logic                axi_areset,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_write,

    output logic [ADDR_W-1:0]   axi_awaddr,
    output logic [2:0]          axi_awprot,
    output logic                axi_awvalid,
    input  logic                axi_awready,

    output logic [DATA_W-1:0]   axi_wdata,
    output logic [DATA_W/8-1:0] axi_wstrb,
    output logic                axi_wvalid,
    input  logic                axi_wready,

    input  logic [1:0]          axi_bresp,
    input  logic                axi_bvalid,
    output logic                axi_bready,

    output logic [ADDR_W-1:0]   axi_araddr,
    output logic [2:0]          axi_arprot,
    output logic                axi_arvalid,
    input  logic                axi_arready,

    input  logic [DATA_W-1:0]   axi_rdata,
    input  logic [1:0]          axi_rresp,
    input  logic                axi_rvalid,
    output logic                axi_rready,

    output logic [CNT_W-1:0]    wr_cnt,
    output logic [CNT_W-1:0]    rd_cnt,
    output logic [CNT_W-1:0]    err_cnt
);

    state_t                state_reg, state_next;

    logic [ADDR_W-1:0]     addr_reg, addr_next;
    logic [DATA_W-1:0]     wdata_reg, wdata_next;
    logic [DATA_W/8-1:0]   wstrb_reg, wstrb_next;

    logic                  awvalid_reg, awvalid_next;
    logic                  wvalid_reg, wvalid_next;
    logic                  aw_done_reg, aw_done_next;
    logic                  w_done_reg, w_done_next;
    logic                  bready_reg, bready_next;
    logic                  arvalid_reg, arvalid_next;
    logic                  rready_reg, rready_next;

    logic                  rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0]     rsp_rdata_reg, rsp_rdata_next;
    logic [1:0]            rsp_resp_reg, rsp_resp_next;
    logic                  rsp_write_reg, rsp_write_next;

    logic [CNT_W-1:0]      wr_cnt_reg, wr_cnt_next;
    logic [CNT_W-1:0]      rd_cnt_reg, rd_cnt_next;
    logic [CNT_W-1:0]      err_cnt_reg, err_cnt_next;

    logic                  aw_fire, w_fire, aw_now, w_now;

    // Gated by reset so nothing is accepted while the block is held in reset.
    assign cmd_ready = (state_reg == IDLE) && !axi_areset;

    assign aw_fire = awvalid_reg && axi_awready;
    assign w_fire  = wvalid_reg && axi_wready;
    assign aw_now  = aw_done_reg || aw_fire;
    assign w_now   = w_done_reg || w_fire;

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        wstrb_next     = wstrb_reg;
        awvalid_next   = awvalid_reg;
        wvalid_next    = wvalid_reg;
        aw_done_next   = aw_done_reg;
        w_done_next    = w_done_reg;
        bready_next    = bready_reg;
        arvalid_next   = arvalid_reg;
        rready_next    = rready_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_resp_next  = rsp_resp_reg;
        rsp_write_next = rsp_write_reg;
        wr_cnt_next    = wr_cnt_reg;
        rd_cnt_next    = rd_cnt_reg;
        err_cnt_next   = err_cnt_reg;

        unique case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    addr_next      = cmd_addr;
                    wdata_next     = cmd_wdata;
                    wstrb_next     = cmd_wstrb;
                    rsp_write_next = cmd_write;
                    if (cmd_write) begin
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        aw_done_next = 1'b0;
                        w_done_next  = 1'b0;
                        state_next   = WR_REQ;
                    end else begin
                        arvalid_next = 1'b1;
                        state_next   = RD_REQ;
                    end
                end
            end

            WR_REQ: begin
                // Address and data channels complete independently, in any order.
                if (aw_fire) begin
                    awvalid_next = 1'b0;
                    aw_done_next = 1'b1;
                end
                if (w_fire) begin
                    wvalid_next = 1'b0;
                    w_done_next = 1'b1;
                end
                if (aw_now && w_now) begin
                    bready_next = 1'b1;
                    state_next  = WR_RESP;
                end
            end

            WR_RESP: begin
                if (axi_bvalid) begin
                    bready_next    = 1'b0;
                    rsp_resp_next  = axi_bresp;
                    rsp_rdata_next = '0;
                    rsp_valid_next = 1'b1;
                    state_next     = RSP;
                end
            end

            RD_REQ: begin
                if (axi_arready) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = RD_DATA;
                end
            end

            RD_DATA: begin
                if (axi_rvalid) begin
                    rready_next    = 1'b0;
                    rsp_rdata_next = axi_rdata;
                    rsp_resp_next  = axi_rresp;
                    rsp_valid_next = 1'b1;
                    state_next     = RSP;
                end
            end

            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    if (rsp_write_reg) begin
                        wr_cnt_next = wr_cnt_reg + 16'd1;
                    end else begin
                        rd_cnt_next = rd_cnt_reg + 16'd1;
                    end
                    if (resp_is_err(rsp_resp_reg)) begin
                        err_cnt_next = sat_inc(err_cnt_reg);
                    end
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
            bready_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            rready_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= '0;
            rsp_write_reg <= 1'b0;
            wr_cnt_reg    <= '0;
            rd_cnt_reg    <= '0;
            err_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            wstrb_reg     <= wstrb_next;
            awvalid_reg   <= awvalid_next;
            wvalid_reg    <= wvalid_next;
            aw_done_reg   <= aw_done_next;
            w_done_reg    <= w_done_next;
            bready_reg    <= bready_next;
            arvalid_reg   <= arvalid_next;
            rready_reg    <= rready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_resp_reg  <= rsp_resp_next;
            rsp_write_reg <= rsp_write_next;
            wr_cnt_reg    <= wr_cnt_next;
            rd_cnt_reg    <= rd_cnt_next;
            err_cnt_reg   <= err_cnt_next;
        end
    end

    assign axi_awaddr  = addr_reg;
    assign axi_awprot  = 3'b000;
    assign axi_awvalid = awvalid_reg;
    assign axi_wdata   = wdata_reg;
    assign axi_wstrb   = wstrb_reg;
    assign axi_wvalid  = wvalid_reg;
    assign axi_bready  = bready_reg;
    assign axi_araddr  = addr_reg;
    assign axi_arprot  = 3'b000;
    assign axi_arvalid = arvalid_reg;
    assign axi_rready  = rready_reg;

    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_resp  = rsp_resp_reg;
    assign rsp_write = rsp_write_reg;

    assign wr_cnt  = wr_cnt_reg;
    assign rd_cnt  = rd_cnt_reg;
    assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master: the initial block plays both the
// command source and a small word-addressed AXI4-Lite slave.
module tb_axi_lite_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [15:0] wr_cnt, rd_cnt, err_cnt;

    int checks = 0;
    int failures = 0;
    logic [31:0] mem [0:15];
    logic [1:0]  last_resp;
    logic [31:0] last_rdata;
    logic        last_write;

    always #5 clk = ~clk;

    axi_lite_cmd_master #(.ADDR_W(16), .DATA_W(32)) dut (
        .axi_aclk(clk), .axi_areset(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_write(rsp_write),
        .axi_awaddr(awaddr), .axi_awprot(awprot), .axi_awvalid(awvalid), .axi_awready(awready),
        .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
        .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
        .axi_araddr(araddr), .axi_arprot(arprot), .axi_arvalid(arvalid), .axi_arready(arready),
        .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready),
        .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .err_cnt(err_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic take_rsp(input string tag);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_rsp_seen"}, {31'd0, rsp_valid}, 32'd1);
        last_resp  = rsp_resp;
        last_rdata = rsp_rdata;
        last_write = rsp_write;
    endtask

    task automatic rsp_handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Write with a slave that accepts AW/W immediately and answers with br.
    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] br, input string tag);
        int n = 0;
        logic aw_seen = 1'b0, w_seen = 1'b0;
        logic [15:0] ca = '0;
        logic [31:0] cd = '0;
        logic [3:0]  cs = '0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        tick();
        cmd_valid = 1'b0;
        awready = 1'b1; wready = 1'b1;
        while (!(aw_seen && w_seen) && n < 20) begin
            if (awvalid && awready) begin aw_seen = 1'b1; ca = awaddr; end
            if (wvalid && wready)   begin w_seen = 1'b1; cd = wdata; cs = wstrb; end
            tick();
            n++;
        end
        chk({tag, "_addr_data_done"}, {30'd0, aw_seen, w_seen}, 32'd3);
        awready = 1'b0; wready = 1'b0;
        for (int b = 0; b < 4; b++) if (cs[b]) mem[ca[5:2]][8*b +: 8] = cd[8*b +: 8];
        bvalid = 1'b1; bresp = br;
        n = 0;
        while (!bready && n < 20) begin tick(); n++; end
        tick();
        bvalid = 1'b0;
        take_rsp(tag);
        rsp_handshake();
    endtask

    // Read answered from the bench memory; rsp_ready held low for hold cycles
    // while a competing command is offered and must be refused.
    task automatic do_read(input logic [15:0] a, input logic [1:0] rr, input int hold,
                           input logic [15:0] exp_rd_before, input string tag);
        int n = 0;
        logic ar_seen = 1'b0;
        logic [15:0] ca = '0;
        logic [31:0] rd_word;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_wdata = '0; cmd_wstrb = '0;
        tick();
        cmd_valid = 1'b0;
        arready = 1'b1;
        while (!ar_seen && n < 20) begin
            if (arvalid && arready) begin ar_seen = 1'b1; ca = araddr; end
            tick();
            n++;
        end
        chk({tag, "_ar_done"}, {31'd0, ar_seen}, 32'd1);
        arready = 1'b0;
        rd_word = mem[ca[5:2]];
        rvalid = 1'b1; rdata = rd_word; rresp = rr;
        n = 0;
        while (!rready && n < 20) begin tick(); n++; end
        tick();
        rvalid = 1'b0; rdata = 32'hDEAD_BEEF;
        take_rsp(tag);
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0FF0;
            tick();
            chk({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
            chk({tag, "_hold_rdata"}, rsp_rdata, rd_word);
            chk({tag, "_hold_resp"}, {30'd0, rsp_resp}, {30'd0, rr});
            chk({tag, "_hold_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
            chk({tag, "_hold_rd_cnt"}, {16'd0, rd_cnt}, {16'd0, exp_rd_before});
        end
        cmd_valid = 1'b0;
        rsp_handshake();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rst = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        tick(); tick();
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_valids", {28'd0, awvalid, wvalid, arvalid, rsp_valid}, 32'd0);
        chk("rst_readies", {30'd0, bready, rready}, 32'd0);
        chk("rst_counters", {wr_cnt, err_cnt}, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Aligned write, zero-wait slave, cycle-accurate.
        cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h2000; cmd_wdata = 32'h001F_6000; cmd_wstrb = 4'hF;
        awready = 1; wready = 1;
        tick();
        cmd_valid = 0;
        chk("al_c1_valids", {30'd0, awvalid, wvalid}, 32'd3);
        chk("al_c1_awaddr", {16'd0, awaddr}, 32'h0000_2000);
        chk("al_c1_wdata", wdata, 32'h001F_6000);
        chk("al_c1_wstrb_prot", {25'd0, wstrb, awprot}, {25'd0, 4'hF, 3'b000});
        chk("al_c1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        awready = 0; wready = 0;
        chk("al_c2_valids", {30'd0, awvalid, wvalid}, 32'd0);
        chk("al_c2_bready", {31'd0, bready}, 32'd1);
        chk("al_c2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        mem[0] = 32'h001F_6000;
        bvalid = 1; bresp = 2'b00;
        tick();
        bvalid = 0;
        chk("al_c3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("al_c3_rsp", {rsp_rdata[29:0], rsp_resp}, 32'd0);
        chk("al_c3_rsp_write", {31'd0, rsp_write}, 32'd1);
        chk("al_c3_bready", {31'd0, bready}, 32'd0);
        rsp_handshake();
        chk("al_wr_cnt", {16'd0, wr_cnt}, 32'd1);
        chk("al_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Skewed write: awready at cycle 1, wready only at cycle 4, strobe 0x3.
        cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0010; cmd_wdata = 32'hA5A5_1234; cmd_wstrb = 4'h3;
        tick();
        cmd_valid = 0;
        awready = 1;
        chk("sk_c1_valids", {30'd0, awvalid, wvalid}, 32'd3);
        tick();
        awready = 0;
        chk("sk_c2_valids", {30'd0, awvalid, wvalid}, 32'd1);
        chk("sk_c2_bready", {31'd0, bready}, 32'd0);
        tick();
        chk("sk_c3_wvalid", {31'd0, wvalid}, 32'd1);
        chk("sk_c3_wdata", wdata, 32'hA5A5_1234);
        tick();
        wready = 1;
        chk("sk_c4_wvalid", {31'd0, wvalid}, 32'd1);
        chk("sk_c4_wdata_strb", {wdata[27:0], wstrb}, {28'h5A5_1234, 4'h3});
        tick();
        wready = 0;
        chk("sk_c5_wvalid_bready", {30'd0, wvalid, bready}, 32'd1);
        mem[4] = 32'h0000_1234;
        bvalid = 1; bresp = 2'b00;
        tick();
        bvalid = 0;
        chk("sk_rsp", {29'd0, rsp_valid, rsp_resp}, {29'd0, 1'b1, 2'b00});
        rsp_handshake();
        tick(); tick();
        chk("sk_single_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("sk_wr_cnt", {16'd0, wr_cnt}, 32'd2);

        // Write then read back through the slave memory.
        do_write(16'h0004, 32'h0000_0001, 4'hF, 2'b00, "wr4");
        chk("wr4_resp", {30'd0, last_resp}, 32'd0);
        chk("wr4_wr_cnt", {16'd0, wr_cnt}, 32'd3);
        do_read(16'h0004, 2'b00, 0, 16'd0, "rd4");
        chk("rd4_rdata", last_rdata, 32'h0000_0001);
        chk("rd4_write", {31'd0, last_write}, 32'd0);
        chk("rd4_rd_cnt", {16'd0, rd_cnt}, 32'd1);

        // Back-pressure on the response, reading the strobed word.
        do_read(16'h0010, 2'b00, 5, 16'd1, "bp");
        chk("bp_rdata", last_rdata, 32'h0000_1234);
        chk("bp_rd_cnt", {16'd0, rd_cnt}, 32'd2);
        chk("bp_wr_cnt", {16'd0, wr_cnt}, 32'd3);

        // Slave error on a read.
        do_read(16'h3000, 2'b10, 0, 16'd2, "err");
        chk("err_resp", {30'd0, last_resp}, 32'd2);
        chk("err_err_cnt", {16'd0, err_cnt}, 32'd1);
        chk("err_rd_cnt", {16'd0, rd_cnt}, 32'd3);

        // Reset in the middle of a write.
        cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0008; cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'hF;
        tick();
        cmd_valid = 0;
        chk("mr_c1_valids", {30'd0, awvalid, wvalid}, 32'd3);
        #1 rst = 1'b1;
        #1;
        chk("mr_async_valids", {30'd0, awvalid, wvalid}, 32'd0);
        chk("mr_async_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("mr_idle", {31'd0, cmd_ready}, 32'd1);
        chk("mr_counters", {wr_cnt, rd_cnt}, 32'd0);
        chk("mr_err_cnt", {16'd0, err_cnt}, 32'd0);
        chk("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        do_write(16'h000C, 32'hCAFE_F00D, 4'hF, 2'b00, "mr_fresh");
        chk("mr_fresh_resp", {29'd0, last_write, last_resp}, 32'd4);
        chk("mr_fresh_wr_cnt", {16'd0, wr_cnt}, 32'd1);
        chk("mr_fresh_mem", mem[3], 32'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
